// File: rtl/gray_frame_ctrl_pkg.sv
// Shared definitions for the grayscale frame sequencer.
package gray_frame_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    // Source memory read latency and converter latency, in clock cycles.
    localparam int RD_LAT   = 1;
    localparam int CONV_LAT = 1;

    // Channel slots inside a packed pixel word: {R,G,B}, R in the MSBs.
    localparam int R_SLOT = 2;
    localparam int G_SLOT = 1;
    localparam int B_SLOT = 0;

endpackage

// File: rtl/gray_frame_ctrl_raster_counter.sv
// Raster-order position counter: linear address plus column/row with wrap.
// last_col and last_row are combinational flags on the current position.
module raster_counter #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_col,
    output logic                  last_row
);

    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int ROW_W = $clog2(HEIGHT + 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    assign last_col = (col == COL_W'(WIDTH - 1));
    assign last_row = (row == ROW_W'(HEIGHT - 1));

    // Advance one pixel per step; after the final pixel return to the origin.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (step) begin
            if (last_col) begin
                col <= '0;
                if (last_row) begin
                    row  <= '0;
                    addr <= '0;
                end else begin
                    row  <= row + ROW_W'(1);
                    addr <= addr + ADDR_WIDTH'(1);
                end
            end else begin
                col  <= col + COL_W'(1);
                addr <= addr + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer for the RGB-to-grayscale stage.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start_i, busy_o low
//   ST_RUN   | issuing source reads in raster order (held off by pause_i)
//   ST_DRAIN | all reads issued, waiting for the last grey write
//
// Pipeline from a read issued in cycle t: data at t+1, colours/done_o at
// t+2, converter result at t+3, destination write at t+4.
module gray_frame_ctrl
    import gray_frame_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    pause_i,
    output logic                    rd_en_o,
    output logic [ADDR_WIDTH-1:0]   rd_addr_o,
    input  logic [3*DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0]   red_o,
    output logic [DATA_WIDTH-1:0]   green_o,
    output logic [DATA_WIDTH-1:0]   blue_o,
    output logic                    done_o,
    input  logic [DATA_WIDTH-1:0]   gray_i,
    input  logic                    gray_done_i,
    output logic                    wr_en_o,
    output logic [ADDR_WIDTH-1:0]   wr_addr_o,
    output logic [DATA_WIDTH-1:0]   wr_data_o,
    output logic                    line_end_o,
    output logic                    frame_done_o,
    output logic                    busy_o
);

    state_t                state;
    logic                  start_acc;
    logic                  rd_issue;
    logic                  rd_last_col;
    logic                  rd_last_row;
    logic                  rd_last;
    logic                  wr_accept;
    logic                  wr_last_col;
    logic                  wr_last_row;
    logic                  pix_vld;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [ADDR_WIDTH-1:0] wr_cnt;

    assign busy_o    = (state != ST_IDLE);
    assign start_acc = (state == ST_IDLE) && start_i;
    // rst gates the strobe so an abort never issues a read in its own cycle.
    assign rd_issue  = (state == ST_RUN) && !pause_i && !rst;
    assign rd_last   = rd_last_col && rd_last_row;
    assign rd_en_o   = rd_issue;
    assign rd_addr_o = rd_cnt;
    // Converter results are only meaningful while a frame is in progress.
    assign wr_accept = gray_done_i && busy_o;

    raster_counter #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_pos (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_acc),
        .step     (rd_issue),
        .addr     (rd_cnt),
        .last_col (rd_last_col),
        .last_row (rd_last_row)
    );

    raster_counter #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_pos (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_acc),
        .step     (wr_accept),
        .addr     (wr_cnt),
        .last_col (wr_last_col),
        .last_row (wr_last_row)
    );

    // Frame sequencing; leave DRAIN in the cycle frame_done_o is shown so
    // busy_o falls exactly one cycle after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_i) state <= ST_RUN;
                ST_RUN:   if (rd_issue && rd_last) state <= ST_DRAIN;
                ST_DRAIN: if (frame_done_o) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Track the read return and present the unpacked pixel to the converter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_vld <= 1'b0;
            done_o  <= 1'b0;
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
        end else begin
            pix_vld <= rd_issue;
            done_o  <= pix_vld;
            red_o   <= pix_vld ? rd_data_i[R_SLOT*DATA_WIDTH +: DATA_WIDTH] : '0;
            green_o <= pix_vld ? rd_data_i[G_SLOT*DATA_WIDTH +: DATA_WIDTH] : '0;
            blue_o  <= pix_vld ? rd_data_i[B_SLOT*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    // Register each accepted grey sample as a destination write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            line_end_o   <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            wr_en_o      <= wr_accept;
            wr_addr_o    <= wr_accept ? wr_cnt : '0;
            wr_data_o    <= wr_accept ? gray_i : '0;
            line_end_o   <= wr_accept && wr_last_col;
            frame_done_o <= wr_accept && wr_last_col && wr_last_row;
        end
    end

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Bench for gray_frame_ctrl: 4x2 frame, source memory and converter models,
// a per-cycle reference model of the expected reads/pixels/writes, and
// directed plus randomized frames.
module tb_gray_frame_ctrl;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 3;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst, start_i, pause_i;
    logic          rd_en_o, done_o, gray_done_i, wr_en_o;
    logic          line_end_o, frame_done_o, busy_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [3*DW-1:0] rd_data_i;
    logic [DW-1:0] red_o, green_o, blue_o, gray_i, wr_data_o;
    logic          force_gd;
    logic [3*DW-1:0] mem [N];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit armed    = 0;

    always #5 clk = ~clk;

    gray_frame_ctrl #(
        .DATA_WIDTH (DW),
        .WIDTH      (W),
        .HEIGHT     (H),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .pause_i      (pause_i),
        .rd_en_o      (rd_en_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_i    (rd_data_i),
        .red_o        (red_o),
        .green_o      (green_o),
        .blue_o       (blue_o),
        .done_o       (done_o),
        .gray_i       (gray_i),
        .gray_done_i  (gray_done_i),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .line_end_o   (line_end_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o)
    );

    // Source memory (1-cycle read, garbage when not read) and a 1-cycle
    // converter computing (R + 2G + B) / 4.
    always @(posedge clk) begin
        rd_data_i   <= rd_en_o ? mem[rd_addr_o] : 24'($urandom);
        gray_done_i <= done_o | force_gd;
        gray_i      <= 8'((int'(red_o) + 2 * int'(green_o) + int'(blue_o)) >> 2);
    end

    function automatic int gray_of(input logic [23:0] px);
        return (int'(px[23:16]) + 2 * int'(px[15:8]) + int'(px[7:0])) >> 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a read issued in cycle c yields pixel c+2 and write c+4.
    typedef struct {
        int rc;
        int idx;
    } item_t;

    item_t pend[$];
    bit    m_busy = 0;
    int    m_rd   = 0;
    int    rc_q[$], ra_q[$], wc_q[$], wa_q[$], wd_q[$], le_q[$], fd_q[$];

    always @(negedge clk) begin
        bit    exp_rd, exp_done, exp_wr, fd_now;
        int    di, wi;
        item_t it;
        cyc++;
        if (armed) begin
            exp_rd   = m_busy && (m_rd < N) && !pause_i && !rst;
            exp_done = 1'b0;
            di       = 0;
            foreach (pend[k]) if (pend[k].rc + 2 == cyc) begin
                exp_done = 1'b1;
                di       = pend[k].idx;
            end
            exp_wr = (pend.size() > 0) && (pend[0].rc + 4 == cyc);
            wi     = exp_wr ? pend[0].idx : 0;

            chk("rd_en", 32'(rd_en_o), 32'(exp_rd));
            if (exp_rd) chk("rd_addr", 32'(rd_addr_o), 32'(m_rd));
            chk("done", 32'(done_o), 32'(exp_done));
            if (exp_done) begin
                chk("red", 32'(red_o), 32'(mem[di][23:16]));
                chk("green", 32'(green_o), 32'(mem[di][15:8]));
                chk("blue", 32'(blue_o), 32'(mem[di][7:0]));
            end else begin
                chk("rgb_idle", 32'({red_o, green_o, blue_o}), 32'(0));
            end
            chk("wr_en", 32'(wr_en_o), 32'(exp_wr));
            if (exp_wr) begin
                chk("wr_addr", 32'(wr_addr_o), 32'(wi));
                chk("wr_data", 32'(wr_data_o), 32'(gray_of(mem[wi])));
                chk("line_end", 32'(line_end_o), 32'((wi % W) == W - 1));
                chk("frame_done", 32'(frame_done_o), 32'(wi == N - 1));
            end else begin
                chk("line_end_idle", 32'(line_end_o), 32'(0));
                chk("frame_done_idle", 32'(frame_done_o), 32'(0));
            end
            chk("busy", 32'(busy_o), 32'(m_busy));

            if (rd_en_o) begin
                rc_q.push_back(cyc);
                ra_q.push_back(int'(rd_addr_o));
            end
            if (wr_en_o) begin
                wc_q.push_back(cyc);
                wa_q.push_back(int'(wr_addr_o));
                wd_q.push_back(int'(wr_data_o));
                le_q.push_back(int'(line_end_o));
                fd_q.push_back(int'(frame_done_o));
            end

            fd_now = exp_wr && (wi == N - 1);
            if (exp_wr) void'(pend.pop_front());
            if (rst) begin
                pend.delete();
                m_busy = 1'b0;
                m_rd   = 0;
            end else begin
                if (exp_rd) begin
                    it.rc  = cyc;
                    it.idx = m_rd;
                    pend.push_back(it);
                    m_rd++;
                end
                if (fd_now) m_busy = 1'b0;
                else if (!m_busy && start_i) begin
                    m_busy = 1'b1;
                    m_rd   = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_fd(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done_o && n < budget);
        chk("frame_done_seen", 32'(frame_done_o), 32'(1));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en_o), 32'(0));
        chk({tag, "_rd_addr"}, 32'(rd_addr_o), 32'(0));
        chk({tag, "_rgb"}, 32'({red_o, green_o, blue_o}), 32'(0));
        chk({tag, "_done"}, 32'(done_o), 32'(0));
        chk({tag, "_wr_en"}, 32'(wr_en_o), 32'(0));
        chk({tag, "_wr_addr"}, 32'(wr_addr_o), 32'(0));
        chk({tag, "_wr_data"}, 32'(wr_data_o), 32'(0));
        chk({tag, "_line_end"}, 32'(line_end_o), 32'(0));
        chk({tag, "_frame_done"}, 32'(frame_done_o), 32'(0));
        chk({tag, "_busy"}, 32'(busy_o), 32'(0));
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
    endtask

    initial begin
        int r0, w0;
        bit fin;
        rst      = 1'b1;
        start_i  = 1'b0;
        pause_i  = 1'b0;
        force_gd = 1'b0;
        fill_random();
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst   = 1'b0;
        armed = 1'b1;
        step();

        // Plain frame, mem[i] = {i,i,i} so grey equals the address.
        for (int i = 0; i < N; i++) mem[i] = {8'(i), 8'(i), 8'(i)};
        r0 = rc_q.size();
        w0 = wc_q.size();
        pulse_start();
        wait_fd(100);
        step();
        chk("busy_after_fd", 32'(busy_o), 32'(0));
        chk("f1_reads", 32'(rc_q.size() - r0), 32'(8));
        chk("f1_writes", 32'(wc_q.size() - w0), 32'(8));
        if (rc_q.size() - r0 == 8 && wc_q.size() - w0 == 8) begin
            chk("f1_rd_consecutive", 32'(rc_q[r0 + 7] - rc_q[r0]), 32'(7));
            chk("f1_latency", 32'(wc_q[w0] - rc_q[r0]), 32'(4));
            for (int i = 0; i < 8; i++) begin
                chk("f1_rd_addr", 32'(ra_q[r0 + i]), 32'(i));
                chk("f1_wr_addr", 32'(wa_q[w0 + i]), 32'(i));
                chk("f1_wr_data", 32'(wd_q[w0 + i]), 32'(i));
                chk("f1_line_end", 32'(le_q[w0 + i]), 32'(i == 3 || i == 7));
                chk("f1_frame_done", 32'(fd_q[w0 + i]), 32'(i == 7));
            end
        end

        // Pause for 5 cycles after the third read.
        fill_random();
        mem[5] = {8'd200, 8'd100, 8'd40};
        r0 = rc_q.size();
        w0 = wc_q.size();
        pulse_start();
        repeat (3) step();
        pause_i = 1'b1;
        repeat (5) step();
        pause_i = 1'b0;
        wait_fd(100);
        step();
        chk("p_reads", 32'(rc_q.size() - r0), 32'(8));
        chk("p_writes", 32'(wc_q.size() - w0), 32'(8));
        if (rc_q.size() - r0 == 8 && wc_q.size() - w0 == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("p_rd_addr", 32'(ra_q[r0 + i]), 32'(i));
                chk("p_wr_addr", 32'(wa_q[w0 + i]), 32'(i));
            end
            chk("p_wr_span", 32'(wc_q[w0 + 7] - wc_q[w0]), 32'(12));
            chk("p_gray_200_100_40", 32'(wd_q[w0 + 5]), 32'(110));
        end

        // start_i held every cycle of a frame is ignored.
        fill_random();
        w0 = wc_q.size();
        start_i = 1'b1;
        repeat (12) step();
        start_i = 1'b0;
        wait_fd(100);
        repeat (5) step();
        chk("spam_writes", 32'(wc_q.size() - w0), 32'(8));
        chk("spam_busy", 32'(busy_o), 32'(0));

        // Abort in RUN after 5 reads.
        fill_random();
        r0 = rc_q.size();
        pulse_start();
        repeat (5) step();
        rst = 1'b1;
        step();
        chk_idle("abort");
        rst = 1'b0;
        chk("abort_reads", 32'(rc_q.size() - r0), 32'(5));
        w0 = wc_q.size();
        repeat (8) step();
        chk("abort_no_writes", 32'(wc_q.size() - w0), 32'(0));
        chk("abort_no_reads", 32'(rc_q.size() - r0), 32'(5));
        w0 = wc_q.size();
        pulse_start();
        wait_fd(100);
        step();
        chk("abort_clean_writes", 32'(wc_q.size() - w0), 32'(8));
        if (wc_q.size() - w0 == 8)
            for (int i = 0; i < 8; i++) chk("abort_clean_addr", 32'(wa_q[w0 + i]), 32'(i));

        // Back-to-back frames, second start the cycle after frame_done_o.
        fill_random();
        w0 = wc_q.size();
        pulse_start();
        wait_fd(100);
        step();
        pulse_start();
        wait_fd(100);
        step();
        chk("b2b_writes", 32'(wc_q.size() - w0), 32'(16));
        if (wc_q.size() - w0 == 16)
            for (int i = 0; i < 16; i++) begin
                chk("b2b_addr", 32'(wa_q[w0 + i]), 32'(i % 8));
                chk("b2b_fd", 32'(fd_q[w0 + i]), 32'(i == 7 || i == 15));
            end

        // Converter strobe while idle must not produce writes.
        repeat (2) step();
        w0 = wc_q.size();
        force_gd = 1'b1;
        repeat (6) step();
        force_gd = 1'b0;
        repeat (3) step();
        chk("idle_gd_writes", 32'(wc_q.size() - w0), 32'(0));

        // Randomized frames with random pause and stray start requests.
        for (int f = 0; f < 4; f++) begin
            fill_random();
            w0 = wc_q.size();
            pulse_start();
            fin = 1'b0;
            for (int n = 0; n < 300 && !fin; n++) begin
                pause_i = ($urandom_range(0, 2) == 0);
                start_i = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                fin = frame_done_o;
                @(posedge clk);
                #1;
            end
            pause_i = 1'b0;
            start_i = 1'b0;
            chk("rand_fd_seen", 32'(fin), 32'(1));
            repeat (2) step();
            chk("rand_writes", 32'(wc_q.size() - w0), 32'(8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_frame_ctrl.md
Name: gray_frame_ctrl

Overview:
- Frame-level sequencer for the RGB-to-grayscale stage.
- On start_i, walks a WIDTH x HEIGHT packed-RGB source memory in raster order, presents each pixel with a valid strobe to the grayscale converter, and collects the converter's output.
- Writes every grey result to a destination memory at the matching raster address.
- Reports busy, end-of-line and end-of-frame to the upstream frame controller feeding the Sobel pipeline.

Parameters:
- DATA_WIDTH, 8, bits per colour channel and per grey sample
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- ADDR_WIDTH, 19, address width; must satisfy 2^ADDR_WIDTH >= WIDTH*HEIGHT

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle frame start request
- pause_i  in  1  suspend issuing new reads while high
- rd_en_o  out  1  source memory read strobe
- rd_addr_o  out  ADDR_WIDTH  source read address
- rd_data_i  in  3*DATA_WIDTH  {R,G,B}, R in MSBs; valid exactly 1 cycle after rd_en_o
- red_o, green_o, blue_o  out  DATA_WIDTH each  to converter colour inputs
- done_o  out  1  to converter done_i (pixel valid)
- gray_i  in  DATA_WIDTH  converter grayscale_o
- gray_done_i  in  1  converter done_o
- wr_en_o  out  1  destination write strobe
- wr_addr_o  out  ADDR_WIDTH  destination address
- wr_data_o  out  DATA_WIDTH  grey sample
- line_end_o  out  1  high with wr_en_o on the last pixel of each line
- frame_done_o  out  1  one-cycle pulse with the final wr_en_o of a frame
- busy_o  out  1  high from start acceptance until frame_done_o

Behaviour:
- Reset (synchronous, active-high): state IDLE; all counters 0; every output 0.
- rst asserted mid-frame aborts immediately: no further reads or writes, and in-flight converter results are dropped.
- FSM states:
  - IDLE: busy_o=0. start_i=1 -> RUN with rd_cnt=0, wr_cnt=0; busy_o=1 from the next cycle.
  - RUN: rd_en_o=!pause_i, rd_addr_o=rd_cnt; rd_cnt increments on each issued read. Issuing read WIDTH*HEIGHT-1 -> DRAIN.
  - DRAIN: rd_en_o=0; wait for outstanding results. Final write -> IDLE.
- start_i while busy_o=1 is ignored.
- Pipeline, read issued at cycle t:
  - rd_data_i valid at t+1.
  - red_o/green_o/blue_o/done_o registered, valid at t+2; done_o=0 and colours=0 otherwise.
  - gray_done_i expected at t+3.
  - wr_en_o/wr_data_o registered at t+4. Total latency rd_en_o -> wr_en_o is 4 cycles.
- Write path:
  - wr_addr_o = wr_cnt, which increments on each write; writes appear in raster order.
  - gray_done_i while not busy is ignored.
- Pause:
  - Takes effect in the same cycle it is asserted: no read is issued while pause_i=1.
  - Up to 3 in-flight pixels still complete and are written.
  - No pixel is skipped or duplicated. pause_i in IDLE/DRAIN has no effect.
- Line and frame tracking:
  - A column counter on the write side (0..WIDTH-1) drives line_end_o at col=WIDTH-1, then wraps to 0.
  - frame_done_o is asserted together with the write at wr_cnt=WIDTH*HEIGHT-1.
  - busy_o drops the following cycle.
- Back-to-back frames: start_i in the cycle after frame_done_o is accepted normally.
- Counter arithmetic is unsigned and never wraps past WIDTH*HEIGHT-1.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, RUN, DRAIN)
  - the pipeline latency constant (RD_LAT=1, CONV_LAT=1)
  - the pixel packing order {R,G,B}
- One natural sub-module: raster_counter (column/line counter with wrap and last-pixel flags), instantiated on both the read and write sides.

Test Plan:
- WIDTH=4, HEIGHT=2, memory[i]={i,i,i}, converter instantiated, start pulse:
  - reads at addresses 0..7 on consecutive cycles;
  - first wr_en_o 4 cycles after the first rd_en_o;
  - writes at wr_addr 0..7;
  - line_end_o on addresses 3 and 7;
  - frame_done_o with address 7; busy_o low the next cycle.
- Same frame, pause_i high for 5 cycles after the 3rd read:
  - exactly 8 reads and 8 writes, no duplicates;
  - a gap appears in wr_en_o;
  - data is correct: pixel {200,100,40} -> gray 110.
- start_i pulsed every cycle during a frame -> ignored; only one frame of 8 writes.
- rst asserted while in RUN after 5 reads:
  - next cycle all outputs are 0 and the state is IDLE;
  - no writes follow;
  - a later start_i runs a clean full frame.
- Two frames back-to-back with start_i the cycle after frame_done_o -> 16 writes, addresses 0..7 twice.
- gray_done_i forced high in IDLE -> no wr_en_o.
